// File: rtl/scalar_alu_pipe.sv
// rtl/scalar_alu_pipe.sv - handshaked scalar ALU with integer/fixed-point modes and iterative multiply
//
// Purpose: accepts one operand/op request at a time and returns one result with NZCV flags.
//   Non-multiply ops take one execute cycle. Multiply runs an N-step shift-add on operand
//   magnitudes and applies the sign at the end. In fixed-point mode add/sub/mul saturate.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   in_valid/ready   - request handshake (ready only while idle)
//   A, B             - signed N-bit operands (Q-format when fp=1)
//   ALUControl       - 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 mul, 111 pass B
//   fp               - 1 selects fixed-point (saturating) mode
//   out_valid/ready  - result handshake; result/flags held until taken
//   result, flags    - N-bit result, flags = {N, Z, C, V}
module scalar_alu_pipe #(
  parameter int N = 24,
  parameter int Q = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALUControl,
  input  logic         fp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N);
  localparam logic [N-1:0]  SAT_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  SAT_MIN  = {1'b1, {(N-1){1'b0}}};

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2:0]     r_op;
  logic           r_fp;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic           r_neg;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_result;
  logic [3:0]     r_flags;

  logic           w_accept;
  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;

  logic [N-1:0]   w_b_eff;
  logic [N:0]     w_sum;
  logic           w_add_ovf;
  logic [N-1:0]   w_alu_res;
  logic           w_alu_c;
  logic           w_alu_v;
  logic [3:0]     w_alu_flags;

  logic [2*N-1:0]        w_prod;
  logic signed [2*N-1:0] w_prod_sh;
  logic [2*N-1:0]        w_mul_sel;
  logic                  w_mul_fits;
  logic [N-1:0]          w_mul_res;
  logic [3:0]            w_mul_flags;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign flags     = r_flags;

  assign w_accept = in_valid && in_ready;

  // Magnitudes of the incoming operands; the most negative value maps to 2^(N-1),
  // which still fits as an unsigned N-bit number.
  assign w_mag_a = A[N-1] ? -A : A;
  assign w_mag_b = B[N-1] ? -B : B;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next = (ALUControl == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: w_next = DONE;
      MUL: begin
        if (r_cnt == CNT_LAST) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Add/sub share one adder; subtraction is A + ~B + 1 so C is "no borrow".
  always_comb begin
    w_b_eff   = (r_op == OP_SUB) ? ~r_b : r_b;
    w_sum     = {1'b0, r_a} + {1'b0, w_b_eff} + {{N{1'b0}}, (r_op == OP_SUB)};
    w_add_ovf = (r_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != r_a[N-1]);
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_alu_c = w_sum[N];
        w_alu_v = w_add_ovf;
        if (r_fp && w_add_ovf) begin
          // Overflow direction follows the sign of A (both effective operands share it).
          w_alu_res = r_a[N-1] ? SAT_MIN : SAT_MAX;
        end else begin
          w_alu_res = w_sum[N-1:0];
        end
      end
      OP_AND:  w_alu_res = r_a & r_b;
      OP_OR:   w_alu_res = r_a | r_b;
      OP_XOR:  w_alu_res = r_a ^ r_b;
      OP_SHL:  w_alu_res = r_a << r_b[SW-1:0];
      OP_PASS: w_alu_res = r_b;
      default: w_alu_res = '0;
    endcase
    w_alu_flags = {w_alu_res[N-1], (w_alu_res == '0), w_alu_c, w_alu_v};
  end

  // Final multiply result: apply sign, optionally rescale by Q (arithmetic shift floors),
  // then range-check against signed N bits.
  always_comb begin
    w_prod     = r_neg ? -r_acc : r_acc;
    w_prod_sh  = $signed(w_prod) >>> Q;
    w_mul_sel  = r_fp ? w_prod_sh : w_prod;
    w_mul_fits = (&w_mul_sel[2*N-1:N-1]) || !(|w_mul_sel[2*N-1:N-1]);
    if (r_fp && !w_mul_fits) begin
      w_mul_res = w_mul_sel[2*N-1] ? SAT_MIN : SAT_MAX;
    end else begin
      w_mul_res = w_mul_sel[N-1:0];
    end
    w_mul_flags = {w_mul_res[N-1], (w_mul_res == '0), 1'b0, !w_mul_fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_fp     <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= A;
        r_b      <= B;
        r_op     <= ALUControl;
        r_fp     <= fp;
        r_acc    <= '0;
        r_mcand  <= {{N{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_neg    <= A[N-1] ^ B[N-1];
        r_cnt    <= '0;
      end
      if (r_state == EXEC) begin
        r_result <= w_alu_res;
        r_flags  <= w_alu_flags;
      end
      if (r_state == MUL) begin
        if (r_cnt != CNT_LAST) begin
          // One shift-add step per cycle, LSB of the multiplier first.
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end else begin
          r_result <= w_mul_res;
          r_flags  <= w_mul_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_scalar_alu_pipe.sv
// tb/tb_scalar_alu_pipe.sv - scoreboard bench for scalar_alu_pipe
module tb_scalar_alu_pipe;

  localparam int N = 24;
  localparam int Q = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic [2:0]    ALUControl;
  logic          fp;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic [3:0]    flags;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   flg;
    int           lat;
  } exp_t;

  exp_t sb[$];

  scalar_alu_pipe #(.N(N), .Q(Q)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .ALUControl(ALUControl),
    .fp(fp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [2:0] op, input logic f,
                                output logic [N-1:0] r, output logic [3:0] fl);
    longint sa, sb_, ua, ub, full;
    longint maxv, minv;
    logic c, v;
    maxv = 64'sd8388607;
    minv = -64'sd8388608;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    c = 1'b0;
    v = 1'b0;
    full = 0;
    r = '0;
    case (op)
      3'd0, 3'd1, 3'd6: begin
        if (op == 3'd0) begin
          full = sa + sb_;
          c = (ua + ub) >= 64'sd16777216;
        end else if (op == 3'd1) begin
          full = sa - sb_;
          c = (ua >= ub);
        end else begin
          full = sa * sb_;
          if (f) full = full >>> Q;
        end
        v = (full > maxv) || (full < minv);
        if (v && f) r = (full < 0) ? 24'h800000 : 24'h7FFFFF;
        else r = full[N-1:0];
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        full = ua << b[4:0];
        r = full[N-1:0];
      end
      default: r = b;
    endcase
    fl = {r[N-1], (r == '0), c, v};
  endfunction

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] op, input logic f, input int hold);
    exp_t e;
    exp_t got_e;
    int w;
    int lat;
    logic [N-1:0] held_res;
    logic [3:0]   held_flg;
    model(a, b, op, f, e.res, e.flg);
    e.lat = (op == 3'd6) ? N + 1 : 1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("idle_wait", in_ready, 1);
    out_ready  = (hold == 0);
    A          = a;
    B          = b;
    ALUControl = op;
    fp         = f;
    in_valid   = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("op%0d fp%0d out_valid", op, f), out_valid, 1);
    if (sb.size() > 0) begin
      got_e = sb.pop_front();
      check($sformatf("op%0d fp%0d a=%h b=%h result", op, f, a, b), result, got_e.res);
      check($sformatf("op%0d fp%0d a=%h b=%h flags", op, f, a, b), flags, got_e.flg);
      check($sformatf("op%0d latency", op), lat, got_e.lat);
    end
    if (hold > 0) begin
      held_res = result;
      held_flg = flags;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("hold out_valid", out_valid, 1);
        check("hold in_ready", in_ready, 0);
        check("hold result", result, got_e.res);
        check("hold flags", flags, got_e.flg);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release out_valid", out_valid, 0);
      check("release in_ready", in_ready, 1);
      check("release result kept", result, held_res);
      check("release flags kept", flags, held_flg);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;
    logic [2:0]   rop;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    A          = '0;
    B          = '0;
    ALUControl = '0;
    fp         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset flags", flags, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(24'h7FFFFF, 24'h000001, 3'd0, 1'b0, 0);
    do_op(24'h7FFF00, 24'h000200, 3'd0, 1'b1, 0);
    do_op(24'h000005, 24'h000005, 3'd1, 1'b0, 0);
    do_op(24'h000180, 24'hFFFE00, 3'd6, 1'b1, 0);
    do_op(24'h001000, 24'h001000, 3'd6, 1'b0, 0);
    do_op(24'h800000, 24'h800000, 3'd6, 1'b0, 0);
    do_op(24'h800000, 24'h800000, 3'd6, 1'b1, 0);
    do_op(24'hFFFFFF, 24'h000001, 3'd6, 1'b1, 0);
    do_op(24'h800000, 24'h000001, 3'd1, 1'b1, 0);
    do_op(24'h000001, 24'h000002, 3'd1, 1'b0, 0);
    do_op(24'h0000A5, 24'h000017, 3'd5, 1'b1, 0);
    do_op(24'h0000A5, 24'h000018, 3'd5, 1'b0, 0);
    do_op(24'h123456, 24'h00F0F0, 3'd2, 1'b1, 0);
    do_op(24'h123456, 24'hABCDEF, 3'd7, 1'b1, 0);
    do_op(24'h123456, 24'h00FF00, 3'd4, 1'b0, 5);

    // Reset in the middle of a multiply, with a request offered on the reset edge.
    @(negedge clk);
    A = 24'h000123; B = 24'h000456; ALUControl = 3'd6; fp = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    ALUControl = 3'd0;
    @(posedge clk);
    #1;
    check("midmul rst out_valid", out_valid, 0);
    check("midmul rst in_ready", in_ready, 1);
    check("midmul rst result", result, 0);
    check("midmul rst flags", flags, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst priority in_ready", in_ready, 1);
    do_op(24'h000002, 24'h000003, 3'd0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = 24'h800000;
        1: ra = 24'h7FFFFF;
        default: ra = 24'($urandom);
      endcase
      rb = (k % 5 == 0) ? 24'($urandom_range(0, 600)) : 24'($urandom);
      do_op(ra, rb, rop, 1'($urandom_range(0, 1)), 0);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
